// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: ALU control codes and the muldiv FSM states.
package mips_pkg;

    localparam logic [3:0] ALU_DIV  = 4'b1000;
    localparam logic [3:0] ALU_MULT = 4'b1001;
    localparam logic [3:0] ALU_MFHI = 4'b1010;
    localparam logic [3:0] ALU_MFLO = 4'b1011;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       alu_ctrl;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, alu_ctrl, is_signed, op_a, op_b, wr_hi, wr_lo, wr_data,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, alu_ctrl, is_signed, op_a, op_b, wr_hi, wr_lo, wr_data,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers. Works on operand
// magnitudes for WIDTH cycles (shift-add / restoring divide), then applies
// signs and writes HI/LO in a single FIX cycle.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    muldiv_unit_if.slave  bus
);

    // Absolute value when the operand is treated as signed, raw otherwise.
    function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;      // {partial/rem, multiplier/quotient}
    logic [WIDTH-1:0]   opnd_q, opnd_d;    // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;  // unmodified dividend for div-by-zero
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               b_zero_q, b_zero_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               busy, accept, last_iter;
    logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= MD_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (accept)    state_d = MD_CALC;
            MD_CALC: if (last_iter) state_d = MD_FIX;
            MD_FIX:                 state_d = MD_IDLE;
            default:                state_d = MD_IDLE;
        endcase
    end

    // FSM outputs: busy flag, acceptance and end-of-iteration decode.
    always_comb begin
        busy      = (state_q != MD_IDLE);
        accept    = (state_q == MD_IDLE) && bus.start &&
                    ((bus.alu_ctrl == ALU_MULT) || (bus.alu_ctrl == ALU_DIV));
        last_iter = (state_q == MD_CALC) && (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Datapath next-state: operand capture, one iteration per CALC cycle, sign fix.
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        a_raw_d   = a_raw_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        b_zero_d  = b_zero_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;

        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opnd_q};
        prod     = neg_res_q ? -acc_q : acc_q;
        quo      = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem      = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        // Direct HI/LO writes only land while idle; a same-edge start is fine
        // because the result overwrites both registers later.
        if (state_q == MD_IDLE) begin
            if (bus.wr_hi) hi_d = bus.wr_data;
            if (bus.wr_lo) lo_d = bus.wr_data;
        end

        if (accept) begin
            is_div_d  = (bus.alu_ctrl == ALU_DIV);
            neg_res_d = bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
            neg_rem_d = bus.is_signed & bus.op_a[WIDTH-1];
            a_raw_d   = bus.op_a;
            b_zero_d  = (bus.op_b == '0);
            cnt_d     = '0;
            dbz_d     = 1'b0;
            if (bus.alu_ctrl == ALU_DIV) begin
                acc_d  = {{WIDTH{1'b0}}, mag_of(bus.op_a, bus.is_signed)};
                opnd_d = mag_of(bus.op_b, bus.is_signed);
            end else begin
                acc_d  = {{WIDTH{1'b0}}, mag_of(bus.op_b, bus.is_signed)};
                opnd_d = mag_of(bus.op_a, bus.is_signed);
            end
        end

        if (state_q == MD_CALC) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (is_div_q) begin
                // Restoring step: the shifted remainder never exceeds WIDTH bits
                // when it is kept, since it is then below the divisor.
                if (!rem_diff[WIDTH])
                    acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else
                    acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
                // Shift-add: carry out of the upper half shifts back in.
                if (acc_q[0]) acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
            end
        end

        if (state_q == MD_FIX) begin
            done_d = 1'b1;
            if (is_div_q && b_zero_q) begin
                hi_d  = a_raw_q;
                lo_d  = '1;
                dbz_d = 1'b1;
            end else if (is_div_q) begin
                hi_d = rem;
                lo_d = quo;
            end else begin
                hi_d = prod[2*WIDTH-1:WIDTH];
                lo_d = prod[WIDTH-1:0];
            end
        end
    end

    // Datapath registers; reset drops any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            a_raw_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            a_raw_q   <= a_raw_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            b_zero_q  <= b_zero_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule
